// File: rtl/fetch_seq_if.sv
// Fetch sequencer bundle: control handshake in, datapath strobes out.
// Latency: n/a (wires only).
// Backpressure: instr_valid is held until ack; no other flow control.
//
// Ports (via modports):
//   master (sequencer side): receives start/branch/branch_addr/iram_dout/ack,
//                            drives PC/IAR/IDR strobes, status and fetch_count.
//   slave  (control/datapath side): the mirror image of master.
interface fetch_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             branch;
    logic [8:0]       branch_addr;
    logic [8:0]       iram_dout;
    logic             ack;
    logic             write_pc;
    logic             inc_pc;
    logic [8:0]       din_pc;
    logic             write_iar;
    logic             inc_iar;
    logic             write_idr;
    logic             instr_valid;
    logic             two_word;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  start, branch, branch_addr, iram_dout, ack,
        output write_pc, inc_pc, din_pc, write_iar, inc_iar, write_idr,
               instr_valid, two_word, busy, halted, fetch_count
    );

    modport slave (
        output start, branch, branch_addr, iram_dout, ack,
        input  write_pc, inc_pc, din_pc, write_iar, inc_iar, write_idr,
               instr_valid, two_word, busy, halted, fetch_count
    );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: Moore FSM strobing PC/IAR/IDR to fetch one instruction from IRAM into IDR.
// Latency: start -> instr_valid in 3 cycles (one-word), 5 (two-word), +1 with branch.
// Backpressure: instr_valid held in VALID until ack; start only accepted in IDLE or VALID with ack.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : fetch_seq_if.master (start/branch/branch_addr/iram_dout/ack in;
//               write_pc/inc_pc/din_pc/write_iar/inc_iar/write_idr/instr_valid/
//               two_word/busy/halted/fetch_count out)
// Optional feature: define FETCH_SEQ_PERF_CNT_EN to build the saturating
// fetch counter; otherwise fetch_count is tied to zero.
module fetch_seq #(
    parameter logic [8:0] HALT_WORD = 9'h1FF,
    parameter int         CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    fetch_seq_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BRANCH   = 3'd1,
        LOAD_IAR = 3'd2,
        READ1    = 3'd3,
        INC_IAR  = 3'd4,
        READ2    = 3'd5,
        VALID    = 3'd6,
        HALT     = 3'd7
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [8:0] din_pc_q;
    logic       two_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore strobes (strobes depend on state_q only).
    always_comb begin
        state_d         = state_q;
        bus.write_pc    = 1'b0;
        bus.inc_pc      = 1'b0;
        bus.write_iar   = 1'b0;
        bus.inc_iar     = 1'b0;
        bus.write_idr   = 1'b0;
        bus.instr_valid = 1'b0;
        bus.busy        = 1'b1;
        bus.halted      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_d = bus.branch ? BRANCH : LOAD_IAR;
                end
            end
            BRANCH: begin
                bus.write_pc = 1'b1;
                state_d      = LOAD_IAR;
            end
            LOAD_IAR: begin
                // IAR takes the pre-increment PC on this same edge.
                bus.write_iar = 1'b1;
                bus.inc_pc    = 1'b1;
                state_d       = READ1;
            end
            READ1: begin
                bus.write_idr = 1'b1;
                if (bus.iram_dout == HALT_WORD) begin
                    state_d = HALT;
                end else if (bus.iram_dout[8]) begin
                    state_d = INC_IAR;
                end else begin
                    state_d = VALID;
                end
            end
            INC_IAR: begin
                bus.inc_iar = 1'b1;
                bus.inc_pc  = 1'b1;
                state_d     = READ2;
            end
            READ2: begin
                bus.write_idr = 1'b1;
                state_d       = VALID;
            end
            VALID: begin
                bus.instr_valid = 1'b1;
                if (bus.ack) begin
                    if (!bus.start) begin
                        state_d = IDLE;
                    end else begin
                        state_d = bus.branch ? BRANCH : LOAD_IAR;
                    end
                end
            end
            HALT: begin
                // Sticky until reset.
                bus.busy   = 1'b0;
                bus.halted = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Branch target is captured on the edge that accepts start, so
    // branch_addr only needs to be stable alongside start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_pc_q <= 9'h000;
        end else if (state_d == BRANCH && state_q != BRANCH) begin
            din_pc_q <= bus.branch_addr;
        end
    end

    // Operand flag follows bit 8 of the first word; a halt word leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            two_word_q <= 1'b0;
        end else if (state_q == READ1 && bus.iram_dout != HALT_WORD) begin
            two_word_q <= bus.iram_dout[8];
        end
    end

    assign bus.din_pc   = din_pc_q;
    assign bus.two_word = two_word_q;

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts entries into VALID only; holding in VALID does not recount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d == VALID && state_q != VALID && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.fetch_count = cnt_q;
`else
    assign bus.fetch_count = '0;
`endif

endmodule
